// File: rtl/cache_perf_monitor_if.sv
// Control, event and readback signals of the cache performance monitor.
// The monitor takes the slave side; whatever drives the events and reads counters takes the master side.
interface cache_perf_monitor_if #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 32
) ();
    localparam int RSW = $clog2(2 + 2 * NUM_CH);

    logic                i_start;
    logic                i_stop;
    logic                i_clear;
    logic                i_snap;
    logic                i_retire;
    logic [1:0]          i_flush_cnt;
    logic [NUM_CH-1:0]   i_ch_access;
    logic [NUM_CH-1:0]   i_ch_miss;
    logic [RSW-1:0]      i_rd_sel;
    logic [CNT_W-1:0]    o_rd_data;
    logic                o_running;
    logic [1+2*NUM_CH:0] o_ovf;
    logic [NUM_CH-1:0]   o_alarm;

    modport master (
        output i_start, i_stop, i_clear, i_snap, i_retire, i_flush_cnt,
               i_ch_access, i_ch_miss, i_rd_sel,
        input  o_rd_data, o_running, o_ovf, o_alarm
    );

    modport slave (
        input  i_start, i_stop, i_clear, i_snap, i_retire, i_flush_cnt,
               i_ch_access, i_ch_miss, i_rd_sel,
        output o_rd_data, o_running, o_ovf, o_alarm
    );
endinterface

// File: rtl/cache_perf_monitor.sv
// Performance counters for the cached pipeline: cycles, retired instructions with squash
// correction, per-channel cache accesses/misses, snapshot readback, overflow flags and hit-rate alarms.
module cache_perf_monitor #(
    parameter int NUM_CH   = 2,
    parameter int CNT_W    = 32,
    parameter bit SAT      = 1'b1,
    parameter int WIN_LOG2 = 6
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    cache_perf_monitor_if.slave  bus
);
    localparam int NCNT = 2 + 2 * NUM_CH;
    localparam int WW   = WIN_LOG2 + 1;
    localparam logic [WW-1:0]    WIN_LEN  = {1'b1, {WIN_LOG2{1'b0}}};
    localparam logic [CNT_W-1:0] ALL_ONES = '1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t              r_state;
    state_t              w_stateNext;
    logic                w_run;
    logic [CNT_W-1:0]    r_cnt        [NCNT];
    logic [CNT_W-1:0]    w_cntNext    [NCNT];
    logic [CNT_W-1:0]    r_shadow     [NCNT];
    logic [CNT_W-1:0]    r_rdData;
    logic [NCNT-1:0]     r_ovf;
    logic [NCNT-1:0]     w_ovfNext;
    logic [NCNT-1:0]     w_evt;
    logic [NUM_CH-1:0]   r_alarm;
    logic [NUM_CH-1:0]   w_alarmNext;
    logic [WW-1:0]       r_winAcc      [NUM_CH];
    logic [WW-1:0]       r_winMiss     [NUM_CH];
    logic [WW-1:0]       w_winAccNext  [NUM_CH];
    logic [WW-1:0]       w_winMissNext [NUM_CH];
    logic [CNT_W+1:0]    w_instrSum;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_stateNext;
    end

    // stop dominates start; neither pulse changes a state that is already there
    always_comb begin
        w_stateNext = r_state;
        if (bus.i_stop)       w_stateNext = IDLE;
        else if (bus.i_start) w_stateNext = RUN;
    end

    assign w_run = (r_state == RUN);

    always_comb begin
        w_evt    = '0;
        w_evt[0] = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            w_evt[2+2*c] = bus.i_ch_access[c];
            w_evt[3+2*c] = bus.i_ch_access[c] & bus.i_ch_miss[c];
        end
    end

    // instr is rebuilt from a two-bit-wider sum: top bit flags a negative result, the next one overflow
    always_comb begin
        w_ovfNext  = r_ovf;
        w_instrSum = {2'b00, r_cnt[1]} + {{(CNT_W+1){1'b0}}, bus.i_retire}
                   - {{CNT_W{1'b0}}, bus.i_flush_cnt};
        for (int i = 0; i < NCNT; i++) begin
            w_cntNext[i] = r_cnt[i];
            if (w_run && w_evt[i]) begin
                if (r_cnt[i] == ALL_ONES) begin
                    w_ovfNext[i] = 1'b1;
                    w_cntNext[i] = SAT ? ALL_ONES : '0;
                end else begin
                    w_cntNext[i] = r_cnt[i] + CNT_W'(1);
                end
            end
        end
        if (w_run) begin
            if (w_instrSum[CNT_W+1]) begin
                w_cntNext[1] = '0;
            end else if (w_instrSum[CNT_W]) begin
                w_ovfNext[1] = 1'b1;
                w_cntNext[1] = SAT ? ALL_ONES : w_instrSum[CNT_W-1:0];
            end else begin
                w_cntNext[1] = w_instrSum[CNT_W-1:0];
            end
        end
    end

    // the closing access of a window is part of its own evaluation
    always_comb begin
        w_alarmNext = r_alarm;
        for (int c = 0; c < NUM_CH; c++) begin
            w_winAccNext[c]  = r_winAcc[c];
            w_winMissNext[c] = r_winMiss[c];
            if (w_run && bus.i_ch_access[c]) begin
                w_winAccNext[c]  = r_winAcc[c] + WW'(1);
                w_winMissNext[c] = r_winMiss[c] + WW'(bus.i_ch_miss[c]);
                if (w_winAccNext[c] == WIN_LEN) begin
                    if ({w_winMissNext[c], 1'b0} > {1'b0, WIN_LEN}) w_alarmNext[c] = 1'b1;
                    w_winAccNext[c]  = '0;
                    w_winMissNext[c] = '0;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NCNT; i++) begin
                r_cnt[i]    <= '0;
                r_shadow[i] <= '0;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                r_winAcc[c]  <= '0;
                r_winMiss[c] <= '0;
            end
            r_ovf    <= '0;
            r_alarm  <= '0;
            r_rdData <= '0;
        end else begin
            r_rdData <= (int'(bus.i_rd_sel) < NCNT) ? r_shadow[bus.i_rd_sel] : '0;
            for (int i = 0; i < NCNT; i++) begin
                r_cnt[i] <= bus.i_clear ? '0 : w_cntNext[i];
                if (bus.i_snap) r_shadow[i] <= bus.i_clear ? '0 : w_cntNext[i];
            end
            for (int c = 0; c < NUM_CH; c++) begin
                r_winAcc[c]  <= bus.i_clear ? '0 : w_winAccNext[c];
                r_winMiss[c] <= bus.i_clear ? '0 : w_winMissNext[c];
            end
            r_ovf   <= bus.i_clear ? '0 : w_ovfNext;
            r_alarm <= bus.i_clear ? '0 : w_alarmNext;
        end
    end

    assign bus.o_rd_data = r_rdData;
    assign bus.o_running = w_run;
    assign bus.o_ovf     = r_ovf;
    assign bus.o_alarm   = r_alarm;
endmodule

// File: tb/tb_cache_perf_monitor.sv
// Drives three monitor variants (32-bit saturating, 4-bit saturating, 4-bit wrapping) with shared
// stimulus and compares every cycle against an arithmetic model of the counters.
module tb_cache_perf_monitor;
    localparam int NCNT     = 6;
    localparam int NDUT     = 3;
    localparam int WIN_LOG2 = 2;
    localparam int WIN_LEN  = 1 << WIN_LOG2;

    logic       clock = 1'b0;
    logic       resetN;
    logic       start, stop, clear, snap, retire;
    logic [1:0] flushCnt, chAccess, chMiss;
    logic [2:0] rdSel;

    logic [31:0] obsRd    [NDUT];
    logic        obsRun   [NDUT];
    logic [5:0]  obsOvf   [NDUT];
    logic [1:0]  obsAlarm [NDUT];

    longint   mCnt     [NDUT][NCNT];
    longint   mShadow  [NDUT][NCNT];
    longint   mRd      [NDUT];
    bit [5:0] mOvf     [NDUT];
    bit [1:0] mAlarm   [NDUT];
    int       mWinAcc  [NDUT][2];
    int       mWinMiss [NDUT][2];
    bit       mRun;

    int testsRun    = 0;
    int testsFailed = 0;

    always #5 clock = ~clock;

    cache_perf_monitor_if #(.NUM_CH(2), .CNT_W(32)) bus0 ();
    cache_perf_monitor_if #(.NUM_CH(2), .CNT_W(4))  bus1 ();
    cache_perf_monitor_if #(.NUM_CH(2), .CNT_W(4))  bus2 ();

    cache_perf_monitor #(.NUM_CH(2), .CNT_W(32), .SAT(1'b1), .WIN_LOG2(WIN_LOG2))
        dut0 (.i_clk(clock), .i_rst_n(resetN), .bus(bus0));
    cache_perf_monitor #(.NUM_CH(2), .CNT_W(4), .SAT(1'b1), .WIN_LOG2(WIN_LOG2))
        dut1 (.i_clk(clock), .i_rst_n(resetN), .bus(bus1));
    cache_perf_monitor #(.NUM_CH(2), .CNT_W(4), .SAT(1'b0), .WIN_LOG2(WIN_LOG2))
        dut2 (.i_clk(clock), .i_rst_n(resetN), .bus(bus2));

    assign bus0.i_start = start;     assign bus1.i_start = start;     assign bus2.i_start = start;
    assign bus0.i_stop = stop;       assign bus1.i_stop = stop;       assign bus2.i_stop = stop;
    assign bus0.i_clear = clear;     assign bus1.i_clear = clear;     assign bus2.i_clear = clear;
    assign bus0.i_snap = snap;       assign bus1.i_snap = snap;       assign bus2.i_snap = snap;
    assign bus0.i_retire = retire;   assign bus1.i_retire = retire;   assign bus2.i_retire = retire;
    assign bus0.i_flush_cnt = flushCnt;
    assign bus1.i_flush_cnt = flushCnt;
    assign bus2.i_flush_cnt = flushCnt;
    assign bus0.i_ch_access = chAccess;
    assign bus1.i_ch_access = chAccess;
    assign bus2.i_ch_access = chAccess;
    assign bus0.i_ch_miss = chMiss;  assign bus1.i_ch_miss = chMiss;  assign bus2.i_ch_miss = chMiss;
    assign bus0.i_rd_sel = rdSel;    assign bus1.i_rd_sel = rdSel;    assign bus2.i_rd_sel = rdSel;

    assign obsRd[0] = bus0.o_rd_data;
    assign obsRd[1] = {28'd0, bus1.o_rd_data};
    assign obsRd[2] = {28'd0, bus2.o_rd_data};
    assign obsRun[0] = bus0.o_running;  assign obsRun[1] = bus1.o_running;  assign obsRun[2] = bus2.o_running;
    assign obsOvf[0] = bus0.o_ovf;      assign obsOvf[1] = bus1.o_ovf;      assign obsOvf[2] = bus2.o_ovf;
    assign obsAlarm[0] = bus0.o_alarm;  assign obsAlarm[1] = bus1.o_alarm;  assign obsAlarm[2] = bus2.o_alarm;

    function automatic int widthOf(int k);
        return (k == 0) ? 32 : 4;
    endfunction

    function automatic bit satOf(int k);
        return (k != 2);
    endfunction

    // a counter value beyond the width marks overflow and then either pins or wraps
    function automatic longint limitCount(int k, int i, longint v);
        longint maxV = (longint'(1) << widthOf(k)) - 1;
        if (v > maxV) begin
            mOvf[k][i] = 1'b1;
            return satOf(k) ? maxV : v - (maxV + 1);
        end
        return v;
    endfunction

    function automatic void modelReset();
        for (int k = 0; k < NDUT; k++) begin
            for (int i = 0; i < NCNT; i++) begin
                mCnt[k][i]    = 0;
                mShadow[k][i] = 0;
            end
            for (int c = 0; c < 2; c++) begin
                mWinAcc[k][c]  = 0;
                mWinMiss[k][c] = 0;
            end
            mRd[k]    = 0;
            mOvf[k]   = '0;
            mAlarm[k] = '0;
        end
        mRun = 1'b0;
    endfunction

    // one clock edge worth of behaviour, using the inputs that were present at the edge
    function automatic void modelStep();
        longint v;
        for (int k = 0; k < NDUT; k++) begin
            mRd[k] = (int'(rdSel) < NCNT) ? mShadow[k][rdSel] : 0;
            if (clear) begin
                for (int i = 0; i < NCNT; i++) begin
                    mCnt[k][i] = 0;
                    if (snap) mShadow[k][i] = 0;
                end
                for (int c = 0; c < 2; c++) begin
                    mWinAcc[k][c]  = 0;
                    mWinMiss[k][c] = 0;
                end
                mOvf[k]   = '0;
                mAlarm[k] = '0;
            end else begin
                if (mRun) begin
                    mCnt[k][0] = limitCount(k, 0, mCnt[k][0] + 1);
                    v = mCnt[k][1] + longint'(retire) - longint'(flushCnt);
                    if (v < 0) v = 0;
                    mCnt[k][1] = limitCount(k, 1, v);
                    for (int c = 0; c < 2; c++) begin
                        if (chAccess[c]) begin
                            mCnt[k][2+2*c] = limitCount(k, 2 + 2 * c, mCnt[k][2+2*c] + 1);
                            if (chMiss[c]) mCnt[k][3+2*c] = limitCount(k, 3 + 2 * c, mCnt[k][3+2*c] + 1);
                            mWinAcc[k][c]  += 1;
                            mWinMiss[k][c] += int'(chMiss[c]);
                            if (mWinAcc[k][c] == WIN_LEN) begin
                                if (mWinMiss[k][c] * 2 > WIN_LEN) mAlarm[k][c] = 1'b1;
                                mWinAcc[k][c]  = 0;
                                mWinMiss[k][c] = 0;
                            end
                        end
                    end
                end
                if (snap) for (int i = 0; i < NCNT; i++) mShadow[k][i] = mCnt[k][i];
            end
        end
        if (stop)       mRun = 1'b0;
        else if (start) mRun = 1'b1;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compareModel();
        for (int k = 0; k < NDUT; k++) begin
            checkOutput($sformatf("d%0d.rd_data", k), 64'(obsRd[k]), 64'(mRd[k]));
            checkOutput($sformatf("d%0d.running", k), 64'(obsRun[k]), 64'(mRun));
            checkOutput($sformatf("d%0d.ovf", k), 64'(obsOvf[k]), 64'(mOvf[k]));
            checkOutput($sformatf("d%0d.alarm", k), 64'(obsAlarm[k]), 64'(mAlarm[k]));
        end
    endtask

    // inputs are applied just after a falling edge, sampled at the rising edge, checked at the next fall
    task automatic applyStimulus(input logic st, input logic sp, input logic cl, input logic sn,
                                 input logic rt, input logic [1:0] fl, input logic [1:0] acc,
                                 input logic [1:0] ms, input logic [2:0] sel);
        start = st; stop = sp; clear = cl; snap = sn; retire = rt;
        flushCnt = fl; chAccess = acc; chMiss = ms; rdSel = sel;
        @(posedge clock);
        modelStep();
        @(negedge clock);
        compareModel();
    endtask

    task automatic randomStep();
        applyStimulus($urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
                      $urandom_range(0, 29) == 0, $urandom_range(0, 4) == 0,
                      1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0,
                      2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
    endtask

    initial begin
        resetN = 1'b0;
        start = 0; stop = 0; clear = 0; snap = 0; retire = 0;
        flushCnt = 0; chAccess = 0; chMiss = 0; rdSel = 0;
        modelReset();
        repeat (2) @(negedge clock);
        compareModel();
        resetN = 1'b1;

        // T2: ten counting cycles with one double squash, snapshot on the stopping cycle
        applyStimulus(1, 0, 0, 0, 0, 2'd0, 2'b00, 2'b00, 3'd0);
        for (int n = 1; n <= 10; n++)
            applyStimulus(0, n == 10, 0, n == 10, 1, (n == 5) ? 2'd2 : 2'd0, 2'b00, 2'b00, 3'd0);
        applyStimulus(0, 0, 0, 0, 0, 2'd0, 2'b00, 2'b00, 3'd0);
        for (int k = 0; k < NDUT; k++) checkOutput($sformatf("T2.d%0d.cycle", k), 64'(obsRd[k]), 64'd10);
        applyStimulus(0, 0, 0, 0, 0, 2'd0, 2'b00, 2'b00, 3'd1);
        for (int k = 0; k < NDUT; k++) checkOutput($sformatf("T2.d%0d.instr", k), 64'(obsRd[k]), 64'd8);

        // T3: a squash larger than the count clamps to zero without flagging
        applyStimulus(0, 0, 1, 0, 0, 2'd0, 2'b00, 2'b00, 3'd0);
        applyStimulus(1, 0, 0, 0, 0, 2'd0, 2'b00, 2'b00, 3'd0);
        applyStimulus(0, 0, 0, 0, 1, 2'd0, 2'b00, 2'b00, 3'd0);
        applyStimulus(0, 1, 0, 1, 0, 2'd3, 2'b00, 2'b00, 3'd0);
        applyStimulus(0, 0, 0, 0, 0, 2'd0, 2'b00, 2'b00, 3'd1);
        for (int k = 0; k < NDUT; k++) begin
            checkOutput($sformatf("T3.d%0d.instr", k), 64'(obsRd[k]), 64'd0);
            checkOutput($sformatf("T3.d%0d.ovf1", k), 64'(obsOvf[k][1]), 64'd0);
        end

        // T4: three misses in a four-access window raise the alarm; two do not
        applyStimulus(0, 0, 1, 0, 0, 2'd0, 2'b00, 2'b00, 3'd0);
        applyStimulus(1, 0, 0, 0, 0, 2'd0, 2'b00, 2'b00, 3'd0);
        for (int n = 1; n <= 4; n++) begin
            applyStimulus(0, 0, 0, 0, 0, 2'd0, 2'b01, (n < 4) ? 2'b01 : 2'b00, 3'd0);
            checkOutput($sformatf("T4.alarm0.after%0d", n), 64'(obsAlarm[0][0]), (n == 4) ? 64'd1 : 64'd0);
        end
        applyStimulus(0, 0, 1, 0, 0, 2'd0, 2'b00, 2'b00, 3'd0);
        for (int n = 1; n <= 4; n++)
            applyStimulus(0, n == 4, 0, 0, 0, 2'd0, 2'b01, (n % 2 == 1) ? 2'b01 : 2'b00, 3'd0);
        checkOutput("T4.alarm0.twoMisses", 64'(obsAlarm[0][0]), 64'd0);

        // T5: seventeen channel-1 accesses saturate or wrap the narrow counters
        applyStimulus(0, 0, 1, 0, 0, 2'd0, 2'b00, 2'b00, 3'd0);
        applyStimulus(1, 0, 0, 0, 0, 2'd0, 2'b00, 2'b00, 3'd0);
        for (int n = 1; n <= 17; n++)
            applyStimulus(0, n == 17, 0, n == 17, 0, 2'd0, 2'b10, 2'b00, 3'd0);
        applyStimulus(0, 0, 0, 0, 0, 2'd0, 2'b00, 2'b00, 3'd4);
        checkOutput("T5.d0.access1", 64'(obsRd[0]), 64'd17);
        checkOutput("T5.d1.access1", 64'(obsRd[1]), 64'd15);
        checkOutput("T5.d2.access1", 64'(obsRd[2]), 64'd1);
        checkOutput("T5.d0.ovf4", 64'(obsOvf[0][4]), 64'd0);
        checkOutput("T5.d1.ovf4", 64'(obsOvf[1][4]), 64'd1);
        checkOutput("T5.d2.ovf4", 64'(obsOvf[2][4]), 64'd1);

        // T6: start+stop together, unqualified misses, clear+snap together
        applyStimulus(0, 0, 1, 0, 0, 2'd0, 2'b00, 2'b00, 3'd0);
        applyStimulus(1, 1, 0, 0, 0, 2'd0, 2'b00, 2'b00, 3'd0);
        checkOutput("T6.startStop.running", 64'(obsRun[0]), 64'd0);
        applyStimulus(1, 0, 0, 0, 0, 2'd0, 2'b00, 2'b00, 3'd0);
        for (int n = 1; n <= 3; n++)
            applyStimulus(0, n == 3, 0, n == 3, 0, 2'd0, 2'b00, 2'b11, 3'd0);
        applyStimulus(0, 0, 0, 0, 0, 2'd0, 2'b00, 2'b00, 3'd3);
        checkOutput("T6.miss0.noAccess", 64'(obsRd[0]), 64'd0);
        applyStimulus(0, 0, 0, 0, 0, 2'd0, 2'b00, 2'b00, 3'd5);
        checkOutput("T6.miss1.noAccess", 64'(obsRd[0]), 64'd0);
        applyStimulus(1, 0, 0, 0, 0, 2'd0, 2'b00, 2'b00, 3'd0);
        applyStimulus(0, 0, 0, 1, 1, 2'd0, 2'b11, 2'b01, 3'd0);
        applyStimulus(0, 0, 1, 1, 1, 2'd1, 2'b11, 2'b11, 3'd0);
        for (int s = 0; s < 8; s++) begin
            applyStimulus(0, 0, 0, 0, 0, 2'd0, 2'b00, 2'b00, 3'(s));
            for (int k = 0; k < NDUT; k++)
                checkOutput($sformatf("T6.d%0d.clearSnap.sel%0d", k, s), 64'(obsRd[k]), 64'd0);
        end

        repeat (400) randomStep();

        // T1: asynchronous reset between edges while running
        applyStimulus(1, 0, 0, 0, 0, 2'd0, 2'b00, 2'b00, 3'd0);
        applyStimulus(0, 0, 0, 0, 1, 2'd0, 2'b11, 2'b01, 3'd0);
        applyStimulus(0, 0, 0, 1, 1, 2'd0, 2'b11, 2'b11, 3'd0);
        applyStimulus(0, 0, 0, 0, 1, 2'd0, 2'b00, 2'b00, 3'd0);
        checkOutput("T1.before.running", 64'(obsRun[0]), 64'd1);
        @(posedge clock);
        modelStep();
        #2 resetN = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            checkOutput($sformatf("T1.d%0d.rd_data", k), 64'(obsRd[k]), 64'd0);
            checkOutput($sformatf("T1.d%0d.running", k), 64'(obsRun[k]), 64'd0);
            checkOutput($sformatf("T1.d%0d.ovf", k), 64'(obsOvf[k]), 64'd0);
            checkOutput($sformatf("T1.d%0d.alarm", k), 64'(obsAlarm[k]), 64'd0);
        end
        modelReset();
        @(negedge clock);
        resetN = 1'b1;
        repeat (40) randomStep();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
